lab3_sweep_ctrl: RTL and testbench

Sequencer that exhaustively drives the 3-input `lab3` combinational datapath (inputs a/b/c, outputs x/y) through all 8 input vectors in hardware. It captures the response and checks it against a parameterised golden table. It sits between a start/done handshake from the lab top level and one `lab3` instance, and replaces manual stimulus sweeping with an on-chip self-test.

---
 rtl/lab3_pkg.sv | 25 ++
 rtl/lab3_sweep_chk.sv | 69 ++++++
 rtl/lab3_sweep_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lab3_sweep_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_pkg.sv
// Shared types and helpers for the lab3 exhaustive sweep sequencer.
// Holds the sweep FSM state encoding, the vector/result sizing and
// the accessor that pulls one {x,y} golden slice out of a packed table.

package lab3_pkg;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } sweep_state_t;

    // Three datapath inputs give eight vectors, two response bits each
    localparam int LAB3_NVEC  = 8;
    localparam int LAB3_RES_W = 16;

    // Returns the expected {x,y} for vector vec from a packed golden table
    function automatic logic [1:0] exp_bits(input logic [LAB3_RES_W-1:0] tbl,
                                            input logic [2:0]            vec);
        return tbl[{vec, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/lab3_sweep_chk.sv
// Golden-response checker for the lab3 sweep.
// Compares each sampled {x,y} against the golden table, counts the
// mismatching vectors and remembers the index of the first one.
// Only instantiated when LAB3_SWEEP_GOLDEN_EN is defined.

module lab3_sweep_chk
    import lab3_pkg::*;
#(
    parameter logic [LAB3_RES_W-1:0] EXP_TABLE = 16'hD668
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       sample_i,
    input  logic [2:0] vec_i,
    input  logic [1:0] xy_i,
    output logic [3:0] err_cnt_o,
    output logic [2:0] first_err_o,
    output logic       first_err_vld_o
);

    logic [3:0] err_cnt_q,       err_cnt_d;
    logic [2:0] first_err_q,     first_err_d;
    logic       first_err_vld_q, first_err_vld_d;
    logic       mismatch;

    // A sample is wrong when the captured pair differs from its golden slice
    always_comb begin
        mismatch = sample_i && (xy_i != exp_bits(EXP_TABLE, vec_i));
    end

    // Clear on sweep acceptance, otherwise accumulate errors and latch the first failing index
    always_comb begin
        err_cnt_d       = err_cnt_q;
        first_err_d     = first_err_q;
        first_err_vld_d = first_err_vld_q;
        if (clr_i) begin
            err_cnt_d       = 4'd0;
            first_err_d     = 3'd0;
            first_err_vld_d = 1'b0;
        end else if (mismatch) begin
            // At most eight samples per sweep, so the count tops out at 8 without wrapping
            err_cnt_d = err_cnt_q + 4'd1;
            if (!first_err_vld_q) begin
                first_err_d     = vec_i;
                first_err_vld_d = 1'b1;
            end
        end
    end

    // Checker result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q       <= 4'd0;
            first_err_q     <= 3'd0;
            first_err_vld_q <= 1'b0;
        end else begin
            err_cnt_q       <= err_cnt_d;
            first_err_q     <= first_err_d;
            first_err_vld_q <= first_err_vld_d;
        end
    end

    assign err_cnt_o       = err_cnt_q;
    assign first_err_o     = first_err_q;
    assign first_err_vld_o = first_err_vld_q;

endmodule

// File: rtl/lab3_sweep_ctrl.sv
// On-chip exhaustive sweep sequencer for the lab3 combinational datapath.
// Steps a/b/c through all eight vectors, holds each for SETTLE_CYC cycles,
// samples {x,y} on the following cycle and packs the responses into result.
// Optional golden comparison is compiled in with LAB3_SWEEP_GOLDEN_EN;
// without it the error outputs are tied off and pass means "sweep completed".

module lab3_sweep_ctrl
    import lab3_pkg::*;
#(
    parameter int                    SETTLE_CYC = 2,
    parameter logic [LAB3_RES_W-1:0] EXP_TABLE  = 16'hD668
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    input  logic                  x,
    input  logic                  y,
    output logic [LAB3_RES_W-1:0] result,
    output logic [3:0]            err_cnt,
    output logic [2:0]            first_err,
    output logic                  first_err_vld,
    output logic                  pass
);

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);
    localparam logic [2:0] VecLast    = 3'(LAB3_NVEC - 1);

    sweep_state_t          state_q,  state_d;
    logic [2:0]            vec_q,    vec_d;
    logic [3:0]            cnt_q,    cnt_d;
    logic [LAB3_RES_W-1:0] result_q, result_d;
    logic                  pass_q,   pass_d;
    logic                  clearRes;
    logic                  sampleEn;
    logic                  noErrors;

    // Next-state logic: sweep sequencing, with abort overriding every transition
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        clearRes = 1'b0;
        sampleEn = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    vec_d    = 3'd0;
                    cnt_d    = 4'd0;
                    pass_d   = 1'b0;
                    clearRes = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == SettleLast) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                sampleEn = 1'b1;
                cnt_d    = 4'd0;
                if (vec_q == VecLast) begin
                    state_d = FINISH;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    state_d = SETTLE;
                end
            end
            FINISH: begin
                state_d = IDLE;
                vec_d   = 3'd0;
                pass_d  = noErrors;
            end
            default: begin
                state_d = IDLE;
                vec_d   = 3'd0;
                cnt_d   = 4'd0;
            end
        endcase
        // Abort drops the sweep: drive lines return to 0, partial results stay, pass is not set
        if (abort) begin
            state_d  = IDLE;
            vec_d    = 3'd0;
            cnt_d    = 4'd0;
            pass_d   = pass_q;
            clearRes = 1'b0;
            sampleEn = 1'b0;
        end
    end

    // Result capture: cleared on acceptance, one {x,y} slice written per sampled vector
    always_comb begin
        result_d = result_q;
        if (clearRes) begin
            result_d = '0;
        end else if (sampleEn) begin
            result_d[{vec_q, 1'b0} +: 2] = {x, y};
        end
    end

    // Sequencer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= 3'd0;
            cnt_q    <= 4'd0;
            result_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            pass_q   <= pass_d;
        end
    end

`ifdef LAB3_SWEEP_GOLDEN_EN
    lab3_sweep_chk #(
        .EXP_TABLE (EXP_TABLE)
    ) u_chk (
        .clk             (clk),
        .rst_n           (rst_n),
        .clr_i           (clearRes),
        .sample_i        (sampleEn),
        .vec_i           (vec_q),
        .xy_i            ({x, y}),
        .err_cnt_o       (err_cnt),
        .first_err_o     (first_err),
        .first_err_vld_o (first_err_vld)
    );

    // Pass requires a clean sweep when the golden table is checked
    always_comb begin
        noErrors = (err_cnt == 4'd0);
    end
`else
    logic unused_golden;

    // Without the comparator the golden table is deliberately left unconnected
    always_comb begin
        unused_golden = ^EXP_TABLE;
    end

    assign err_cnt       = 4'd0;
    assign first_err     = 3'd0;
    assign first_err_vld = 1'b0;

    // Pass only signals that the sweep ran to completion
    always_comb begin
        noErrors = 1'b1;
    end
`endif

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FINISH) && !abort;
    assign a      = vec_q[2];
    assign b      = vec_q[1];
    assign c      = vec_q[0];
    assign result = result_q;
    assign pass   = pass_q;

endmodule

// File: tb/tb_lab3_sweep_ctrl.sv
// Self-checking bench for lab3_sweep_ctrl.
// Two instances: dut0 with the default settle time and dut1 with SETTLE_CYC=1.
// The datapath is a full adder (x = sum, y = carry) with a per-vector fault
// mask XORed onto its outputs; expectations come from the adder arithmetic.

module tb_lab3_sweep_ctrl;

    localparam int S0 = 2;
    localparam int S1 = 1;

`ifdef LAB3_SWEEP_GOLDEN_EN
    localparam bit GoldenEn = 1'b1;
`else
    localparam bit GoldenEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start0, abort0, start1, abort1;
    logic        busy0, done0, a0, b0, c0, x0, y0, firstErrVld0, pass0;
    logic        busy1, done1, a1, b1, c1, x1, y1, firstErrVld1, pass1;
    logic [15:0] result0, result1;
    logic [3:0]  errCnt0, errCnt1;
    logic [2:0]  firstErr0, firstErr1;
    logic [1:0]  xy0, xy1;
    logic [1:0]  faultMask [8];

    int total = 0;
    int bad   = 0;

    lab3_sweep_ctrl #(.SETTLE_CYC(S0), .EXP_TABLE(16'hD668)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .busy(busy0), .done(done0), .a(a0), .b(b0), .c(c0), .x(x0), .y(y0),
        .result(result0), .err_cnt(errCnt0), .first_err(firstErr0),
        .first_err_vld(firstErrVld0), .pass(pass0)
    );

    lab3_sweep_ctrl #(.SETTLE_CYC(S1), .EXP_TABLE(16'hD668)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .a(a1), .b(b1), .c(c1), .x(x1), .y(y1),
        .result(result1), .err_cnt(errCnt1), .first_err(firstErr1),
        .first_err_vld(firstErrVld1), .pass(pass1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full adder: {sum, carry} of the three input bits
    function automatic logic [1:0] faModel(input int v);
        int s;
        logic [1:0] r;
        s    = v % 2 + (v / 2) % 2 + (v / 4) % 2;
        r[1] = (s % 2) == 1;
        r[0] = (s >= 2);
        return r;
    endfunction

    // Datapath models with injected faults
    always_comb begin
        xy0 = faModel(int'({a0, b0, c0})) ^ faultMask[{a0, b0, c0}];
        xy1 = faModel(int'({a1, b1, c1})) ^ faultMask[{a1, b1, c1}];
    end
    assign x0 = xy0[1];
    assign y0 = xy0[0];
    assign x1 = xy1[1];
    assign y1 = xy1[0];

    // Packed responses of the first n vectors
    function automatic logic [15:0] expResult(input int n);
        logic [15:0] r;
        r = 16'h0;
        for (int v = 0; v < n; v++) r[2*v +: 2] = faModel(v) ^ faultMask[v];
        return r;
    endfunction

    function automatic int expErrCnt(input int n);
        int e;
        e = 0;
        for (int v = 0; v < n; v++) if (faultMask[v] != 2'b00) e++;
        return GoldenEn ? e : 0;
    endfunction

    function automatic int expFirst(input int n);
        for (int v = 0; v < n; v++) if (faultMask[v] != 2'b00) return v;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomFaults();
        for (int v = 0; v < 8; v++)
            faultMask[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    endtask

    task automatic test_reset();
        total++;
        if ({busy0, done0, a0, b0, c0, result0, errCnt0, firstErr0, firstErrVld0, pass0} !== 31'h0) begin
            bad++;
            $display("[TB] FAIL reset_dut0: got busy=%b done=%b abc=%b%b%b res=%h err=%0d ferr=%0d vld=%b pass=%b, need all 0",
                     busy0, done0, a0, b0, c0, result0, errCnt0, firstErr0, firstErrVld0, pass0);
        end
        total++;
        if ({busy1, done1, a1, b1, c1, result1, errCnt1, firstErr1, firstErrVld1, pass1} !== 31'h0) begin
            bad++;
            $display("[TB] FAIL reset_dut1: got busy=%b done=%b res=%h, need all 0", busy1, done1, result1);
        end
    endtask

    // Full sweep on dut0 with per-cycle drive checks and final result checks
    task automatic test_sweep(input string name);
        int ef;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int cyc = 0; cyc < 8 * (S0 + 1); cyc++) begin
            total++;
            if (busy0 !== 1'b1 || done0 !== 1'b0 || {a0, b0, c0} !== 3'(cyc / (S0 + 1))) begin
                bad++;
                $display("[TB] FAIL %s_cycle%0d: got busy=%b done=%b abc=%b%b%b, need busy=1 done=0 abc=%0d",
                         name, cyc, busy0, done0, a0, b0, c0, cyc / (S0 + 1));
            end
            tick();
        end
        total++;
        if (done0 !== 1'b1 || busy0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_done: got done=%b busy=%b at cycle %0d, need 1/1", name, done0, busy0, 8 * (S0 + 1));
        end
        tick();
        ef = expFirst(8);
        total++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_after_done: got done=%b busy=%b, need 0/0", name, done0, busy0);
        end
        total++;
        if (result0 !== expResult(8)) begin
            bad++;
            $display("[TB] FAIL %s_result: got %h, need %h", name, result0, expResult(8));
        end
        total++;
        if (errCnt0 !== 4'(expErrCnt(8)) || pass0 !== (expErrCnt(8) == 0)) begin
            bad++;
            $display("[TB] FAIL %s_errcnt_pass: got err=%0d pass=%b, need err=%0d pass=%b",
                     name, errCnt0, pass0, expErrCnt(8), expErrCnt(8) == 0);
        end
        total++;
        if (firstErrVld0 !== (GoldenEn && ef >= 0) || firstErr0 !== ((GoldenEn && ef >= 0) ? 3'(ef) : 3'd0)) begin
            bad++;
            $display("[TB] FAIL %s_first_err: got vld=%b idx=%0d, need vld=%b idx=%0d",
                     name, firstErrVld0, firstErr0, GoldenEn && ef >= 0, (GoldenEn && ef >= 0) ? ef : 0);
        end
    endtask

    task automatic test_nominal();
        for (int v = 0; v < 8; v++) faultMask[v] = 2'b00;
        test_sweep("nominal");
    endtask

    task automatic test_fault_vec5();
        for (int v = 0; v < 8; v++) faultMask[v] = 2'b00;
        faultMask[5] = 2'b10;
        test_sweep("fault_vec5");
    endtask

    task automatic test_random_faults();
        for (int i = 0; i < 4; i++) begin
            randomFaults();
            test_sweep($sformatf("random%0d", i));
        end
    endtask

    task automatic test_abort();
        int nCap;
        bit sawDone;
        randomFaults();
        nCap = 0;
        for (int v = 0; v < 8; v++) if (v * (S0 + 1) + S0 < 10) nCap++;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        abort0 = 1'b1;
        #1;
        total++;
        if (done0 !== 1'b0 || busy0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_cycle10: got done=%b busy=%b, need 0/1", done0, busy0);
        end
        tick();
        abort0 = 1'b0;
        total++;
        if (busy0 !== 1'b0 || {a0, b0, c0} !== 3'b000 || pass0 !== 1'b0 || done0 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_idle: got busy=%b abc=%b%b%b pass=%b done=%b, need 0/000/0/0",
                     busy0, a0, b0, c0, pass0, done0);
        end
        total++;
        if (result0 !== expResult(nCap) || errCnt0 !== 4'(expErrCnt(nCap))) begin
            bad++;
            $display("[TB] FAIL abort_partial: got res=%h err=%0d, need res=%h err=%0d",
                     result0, errCnt0, expResult(nCap), expErrCnt(nCap));
        end
        sawDone = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done0 === 1'b1 || busy0 === 1'b1) sawDone = 1'b1;
            tick();
        end
        total++;
        if (sawDone !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_no_done: got activity=%b after abort, need 0", sawDone);
        end
        test_sweep("after_abort");
    endtask

    // start and abort together in IDLE: abort wins and held results survive
    task automatic test_start_abort_idle();
        logic [15:0] held;
        held = expResult(8);
        start0 = 1'b1;
        abort0 = 1'b1;
        tick();
        start0 = 1'b0;
        abort0 = 1'b0;
        total++;
        if (busy0 !== 1'b0 || result0 !== held) begin
            bad++;
            $display("[TB] FAIL start_abort_idle: got busy=%b res=%h, need 0 %h", busy0, result0, held);
        end
    endtask

    task automatic test_async_reset();
        bit anyBusy;
        randomFaults();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy0, done0, a0, b0, c0, result0, errCnt0, firstErr0, firstErrVld0, pass0} !== 31'h0) begin
            bad++;
            $display("[TB] FAIL async_reset: got busy=%b abc=%b%b%b res=%h err=%0d pass=%b, need all 0",
                     busy0, a0, b0, c0, result0, errCnt0, pass0);
        end
        #10;
        rst_n = 1'b1;
        anyBusy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy0 !== 1'b0) anyBusy = 1'b1;
        end
        total++;
        if (anyBusy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release_idle: got busy seen=%b, need 0", anyBusy);
        end
        test_sweep("after_reset");
    endtask

    // dut1 with start held high: sweep, one idle cycle, then an immediate second sweep
    task automatic test_back_to_back();
        randomFaults();
        start1 = 1'b1;
        tick();
        for (int cyc = 0; cyc < 8 * (S1 + 1); cyc++) begin
            total++;
            if (busy1 !== 1'b1 || done1 !== 1'b0 || {a1, b1, c1} !== 3'(cyc / (S1 + 1))) begin
                bad++;
                $display("[TB] FAIL b2b_cycle%0d: got busy=%b done=%b abc=%b%b%b, need 1/0/%0d",
                         cyc, busy1, done1, a1, b1, c1, cyc / (S1 + 1));
            end
            tick();
        end
        total++;
        if (done1 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_done16: got done=%b, need 1", done1);
        end
        tick();
        total++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || result1 !== expResult(8) || pass1 !== (expErrCnt(8) == 0)) begin
            bad++;
            $display("[TB] FAIL b2b_gap: got busy=%b done=%b res=%h pass=%b, need 0/0/%h/%b",
                     busy1, done1, result1, pass1, expResult(8), expErrCnt(8) == 0);
        end
        tick();
        total++;
        if (busy1 !== 1'b1 || {a1, b1, c1} !== 3'b000 || result1 !== 16'h0 || pass1 !== 1'b0 ||
            errCnt1 !== 4'd0 || firstErrVld1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_restart: got busy=%b abc=%b%b%b res=%h pass=%b err=%0d vld=%b, need 1/000/0/0/0/0",
                     busy1, a1, b1, c1, result1, pass1, errCnt1, firstErrVld1);
        end
        start1 = 1'b0;
        for (int cyc = 0; cyc < 8 * (S1 + 1); cyc++) tick();
        total++;
        if (done1 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_second_done: got done=%b, need 1", done1);
        end
        tick();
        total++;
        if (result1 !== expResult(8) || errCnt1 !== 4'(expErrCnt(8))) begin
            bad++;
            $display("[TB] FAIL b2b_second_result: got res=%h err=%0d, need %h %0d",
                     result1, errCnt1, expResult(8), expErrCnt(8));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        abort0 = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
        for (int v = 0; v < 8; v++) faultMask[v] = 2'b00;
        #12;
        test_reset();
        #10;
        rst_n = 1'b1;
        tick();
        test_nominal();
        test_fault_vec5();
        test_start_abort_idle();
        test_random_faults();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
